// File: rtl/pkt_frame_buf_pkg.sv
// Shared constants, FSM state types and the bit-serial CRC-8 step used by pkt_frame_buf.
package pkt_frame_buf_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_CRC
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_DATA,
        R_CRC
    } rd_state_t;

    // One byte of CRC-8 folded into the running value, MSB of the byte first.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[7] ^ data[i]) begin
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/pkt_frame_buf_crc8.sv
// Running CRC-8 accumulator: clear restarts from CRC8_INIT, enable folds in one data byte.
module crc8_unit
    import pkt_frame_buf_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    // clear together with enable starts a new frame with its first byte already folded in
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc <= CRC8_INIT;
        end else if (enable) begin
            crc <= crc8_next(clear ? CRC8_INIT : crc, data);
        end else if (clear) begin
            crc <= CRC8_INIT;
        end
    end

endmodule

// File: rtl/pkt_frame_buf.sv
// Frame store-and-replay buffer with a circular word store and a FIFO frame table.
// Define PKT_FRAME_BUF_CRC_CHECK_EN to reject frames whose trailing CRC byte is wrong.
module pkt_frame_buf
    import pkt_frame_buf_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 64,
    parameter int MAX_FRAMES = 4
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic                              stop,
    input  logic [DATA_W-1:0]                 datain,
    input  logic                              start_read,
    output logic [DATA_W-1:0]                 dataout,
    output logic                              startoutput,
    output logic                              stopoutput,
    output logic [$clog2(MAX_FRAMES+1)-1:0]   frames_avail,
    output logic                              busy,
    output logic                              crc_err,
    output logic                              ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int UW = $clog2(DEPTH + 1);
    localparam int IW = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
    localparam int FW = $clog2(MAX_FRAMES + 1);
    localparam logic [UW-1:0] DEPTH_U = UW'(DEPTH);

    wr_state_t         wstate, wstate_n;
    rd_state_t         rstate, rstate_n;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     tbl_base [MAX_FRAMES];
    logic [UW-1:0]     tbl_len  [MAX_FRAMES];
    logic [IW-1:0]     tbl_head, tbl_tail;
    logic [FW-1:0]     fcount;

    logic [AW-1:0]     wr_tail, wr_addr, rd_addr;
    logic [UW-1:0]     wcnt, cnt_n, wr_off, used, free_words;
    logic [UW-1:0]     rd_idx, rd_idx_n, head_len;
    logic              wdrop, drop_n, mem_we, commit, pop;
    logic              begin_frame, table_full, crc_ok, last_word;

    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
        return (i == IW'(MAX_FRAMES - 1)) ? '0 : i + 1'b1;
    endfunction

    assign free_words  = DEPTH_U - used;
    assign table_full  = (fcount == FW'(MAX_FRAMES));
    assign begin_frame = start && (wstate != W_CRC);
    assign wr_addr     = wr_tail + wr_off[AW-1:0];
    assign head_len    = tbl_len[tbl_head];
    assign rd_addr     = tbl_base[tbl_head] + rd_idx[AW-1:0];
    assign last_word   = (rd_idx == head_len - UW'(1));

`ifdef PKT_FRAME_BUF_CRC_CHECK_EN
    logic [7:0] crc_val;

    crc8_unit u_crc (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (begin_frame),
        .enable  (begin_frame || (wstate == W_DATA)),
        .data    (datain[7:0]),
        .crc     (crc_val)
    );

    assign crc_ok = (crc_val == datain[7:0]);
`else
    assign crc_ok = 1'b1;
`endif

    assign crc_err = (wstate == W_CRC) && !wdrop && !crc_ok;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wstate <= W_IDLE;
            rstate <= R_IDLE;
        end else begin
            wstate <= wstate_n;
            rstate <= rstate_n;
        end
    end

    // A frame is dropped as soon as its payload plus the CRC word would not fit;
    // a new start always rewinds to the committed tail, so aborts need no undo.
    always_comb begin
        wstate_n = wstate;
        cnt_n    = wcnt;
        drop_n   = wdrop;
        wr_off   = wcnt;
        mem_we   = 1'b0;
        commit   = 1'b0;
        ovf      = 1'b0;
        if (begin_frame) begin
            cnt_n    = UW'(1);
            drop_n   = table_full || (free_words <= UW'(1));
            wr_off   = '0;
            mem_we   = !drop_n;
            wstate_n = stop ? W_CRC : W_DATA;
        end else begin
            case (wstate)
                W_DATA: begin
                    drop_n = wdrop || (free_words <= wcnt + UW'(1));
                    mem_we = !drop_n;
                    if (!drop_n) begin
                        cnt_n = wcnt + UW'(1);
                    end
                    if (stop) begin
                        wstate_n = W_CRC;
                    end
                end
                W_CRC: begin
                    mem_we   = !wdrop;
                    ovf      = wdrop;
                    commit   = !wdrop && crc_ok;
                    wstate_n = W_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rstate_n = rstate;
        rd_idx_n = rd_idx;
        pop      = 1'b0;
        case (rstate)
            R_IDLE: begin
                if (start_read && (fcount != '0)) begin
                    rstate_n = R_DATA;
                    rd_idx_n = '0;
                end
            end
            R_DATA: begin
                rd_idx_n = rd_idx + UW'(1);
                if (last_word) begin
                    rstate_n = R_CRC;
                end
            end
            R_CRC: begin
                pop      = 1'b1;
                rstate_n = R_IDLE;
            end
            default: rstate_n = R_IDLE;
        endcase
    end

    // Space held by the frame being replayed is released together with its table entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wcnt     <= '0;
            wdrop    <= 1'b0;
            wr_tail  <= '0;
            used     <= '0;
            tbl_head <= '0;
            tbl_tail <= '0;
            fcount   <= '0;
            rd_idx   <= '0;
        end else begin
            wcnt   <= cnt_n;
            wdrop  <= drop_n;
            rd_idx <= rd_idx_n;
            if (commit) begin
                wr_tail  <= wr_tail + wcnt[AW-1:0] + AW'(1);
                tbl_tail <= idx_inc(tbl_tail);
            end
            if (pop) begin
                tbl_head <= idx_inc(tbl_head);
            end
            used <= used + (commit ? wcnt + UW'(1) : '0) - (pop ? head_len + UW'(1) : '0);
            case ({commit, pop})
                2'b10:   fcount <= fcount + 1'b1;
                2'b01:   fcount <= fcount - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[wr_addr] <= datain;
        end
        if (commit) begin
            tbl_base[tbl_tail] <= wr_tail;
            tbl_len[tbl_tail]  <= wcnt;
        end
    end

    assign busy         = (rstate != R_IDLE);
    assign dataout      = busy ? mem[rd_addr] : '0;
    assign startoutput  = (rstate == R_DATA) && (rd_idx == '0);
    assign stopoutput   = (rstate == R_DATA) && last_word;
    assign frames_avail = fcount;

endmodule

// File: tb/tb_pkt_frame_buf.sv
// Self-checking bench for pkt_frame_buf: directed corner cases plus random frames vs a frame-queue model.
module tb_pkt_frame_buf;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int MAXF   = 4;
    localparam int FW     = $clog2(MAXF + 1);
`ifdef PKT_FRAME_BUF_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic              clock, reset_n, start, stop, start_read;
    logic [DATA_W-1:0] datain, dataout;
    logic              startoutput, stopoutput, busy, crc_err, ovf;
    logic [FW-1:0]     frames_avail;

    int          checkCount = 0;
    int          errorCount = 0;
    int          mLen[$];
    logic [7:0]  mData[$];

    pkt_frame_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_FRAMES(MAXF)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .stop         (stop),
        .datain       (datain),
        .start_read   (start_read),
        .dataout      (dataout),
        .startoutput  (startoutput),
        .stopoutput   (stopoutput),
        .frames_avail (frames_avail),
        .busy         (busy),
        .crc_err      (crc_err),
        .ovf          (ovf)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // CRC-8 as polynomial long division of the message (augmented by 8 zero bits) by x^8+x^2+x+1.
    function automatic logic [7:0] crcModel(input logic [7:0] pl[$]);
        int r;
        int bits[$];
        r = 0;
        foreach (pl[i]) begin
            for (int b = 7; b >= 0; b--) bits.push_back(int'(pl[i][b]));
        end
        for (int b = 0; b < 8; b++) bits.push_back(0);
        foreach (bits[i]) begin
            r = (r << 1) | bits[i];
            if ((r & 'h100) != 0) r = r ^ 'h107;
        end
        return 8'(r);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit p, input logic [7:0] d, input bit rd);
        @(posedge clock);
        #1;
        start      = s;
        stop       = p;
        datain     = d;
        start_read = rd;
        #4;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic modelPop();
        int n;
        logic [7:0] tmp;
        n = mLen.pop_front();
        for (int i = 0; i <= n; i++) tmp = mData.pop_front();
    endtask

    task automatic sendWords(input logic [7:0] pl[$], input logic [7:0] crcw, input int abortLen);
        int n;
        int used;
        bit expDrop, expErr;
        n    = pl.size();
        used = 0;
        foreach (mLen[i]) used += mLen[i] + 1;
        for (int i = 0; i < abortLen; i++) applyStimulus(i == 0, 1'b0, 8'($urandom), 1'b0);
        expDrop = (mLen.size() >= MAXF) || (n + 1 > DEPTH - used);
        expErr  = !expDrop && CRC_EN && (crcw != crcModel(pl));
        for (int i = 0; i < n; i++) applyStimulus(i == 0, i == n - 1, pl[i], 1'b0);
        applyStimulus(1'b0, 1'b0, crcw, 1'b0);
        checkOutput("wr_ovf", 32'(ovf), 32'(expDrop));
        checkOutput("wr_crc_err", 32'(crc_err), 32'(expErr));
        if (!expDrop && !expErr) begin
            mLen.push_back(n);
            foreach (pl[i]) mData.push_back(pl[i]);
            mData.push_back(crcw);
        end
        idleCycle();
        checkOutput("wr_frames_avail", 32'(frames_avail), mLen.size());
    endtask

    task automatic sendRandom(input int n, input bit bad, input int abortLen);
        logic [7:0] pl[$];
        logic [7:0] c;
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
        c = crcModel(pl);
        if (bad) c = c ^ 8'($urandom_range(1, 255));
        sendWords(pl, c, abortLen);
    endtask

    task automatic replayFrame();
        int n;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("rd_req_busy", 32'(busy), 0);
        if (mLen.size() == 0) begin
            idleCycle();
            checkOutput("rd_ignored_busy", 32'(busy), 0);
            checkOutput("rd_ignored_data", 32'(dataout), 0);
            checkOutput("rd_ignored_sop", 32'(startoutput), 0);
            return;
        end
        n = mLen[0];
        for (int i = 0; i < n; i++) begin
            idleCycle();
            checkOutput("rd_busy", 32'(busy), 1);
            checkOutput("rd_data", 32'(dataout), 32'(mData[i]));
            checkOutput("rd_sop", 32'(startoutput), 32'(i == 0));
            checkOutput("rd_eop", 32'(stopoutput), 32'(i == n - 1));
        end
        idleCycle();
        checkOutput("rd_crc_data", 32'(dataout), 32'(mData[n]));
        checkOutput("rd_crc_busy", 32'(busy), 1);
        checkOutput("rd_crc_flags", 32'({startoutput, stopoutput}), 0);
        modelPop();
        idleCycle();
        checkOutput("rd_done_busy", 32'(busy), 0);
        checkOutput("rd_done_data", 32'(dataout), 0);
        checkOutput("rd_done_avail", 32'(frames_avail), mLen.size());
    endtask

    task automatic drain();
        while (mLen.size() > 0) replayFrame();
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] c;
        int         op;

        reset_n    = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        start_read = 1'b0;
        datain     = '0;
        #3;
        checkOutput("rst_dataout", 32'(dataout), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_avail", 32'(frames_avail), 0);
        checkOutput("rst_flags", 32'({startoutput, stopoutput, ovf, crc_err}), 0);
        #9 reset_n = 1'b1;

        pl = '{8'h01, 8'h02};
        sendWords(pl, 8'h1B, 0);
        checkOutput("known_frame_avail", 32'(frames_avail), 1);
        replayFrame();

        pl = '{8'h01};
        sendWords(pl, 8'h00, 0);
        drain();

        sendRandom(16, 1'b0, 0);
        sendRandom(3, 1'b0, 0);
        drain();
        sendRandom(15, 1'b0, 0);
        drain();

        repeat (5) sendRandom(1, 1'b0, 0);
        checkOutput("tbl_full_avail", 32'(frames_avail), MAXF);
        repeat (4) replayFrame();
        replayFrame();

        // start_read on the commit cycle of the only frame is too early; one cycle later it is taken
        pl = '{8'hA5};
        c  = crcModel(pl);
        applyStimulus(1'b1, 1'b1, 8'hA5, 1'b0);
        applyStimulus(1'b0, 1'b0, c, 1'b1);
        checkOutput("ovl_commit_busy", 32'(busy), 0);
        mLen.push_back(1);
        mData.push_back(8'hA5);
        mData.push_back(c);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("ovl_avail", 32'(frames_avail), 1);
        checkOutput("ovl_ignored_busy", 32'(busy), 0);
        idleCycle();
        checkOutput("ovl_sop", 32'(startoutput), 1);
        checkOutput("ovl_data", 32'(dataout), 32'(8'hA5));
        idleCycle();
        checkOutput("ovl_crc", 32'(dataout), 32'(c));
        modelPop();
        idleCycle();
        checkOutput("ovl_done_avail", 32'(frames_avail), 0);

        // commit of frame B lands on the same edge as the end of replaying frame A
        sendRandom(1, 1'b0, 0);
        pl = '{8'h3C};
        c  = crcModel(pl);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h3C, 1'b0);
        checkOutput("sim_sop", 32'(startoutput), 1);
        checkOutput("sim_data", 32'(dataout), 32'(mData[0]));
        applyStimulus(1'b0, 1'b0, c, 1'b0);
        checkOutput("sim_crc", 32'(dataout), 32'(mData[1]));
        modelPop();
        mLen.push_back(1);
        mData.push_back(8'h3C);
        mData.push_back(c);
        idleCycle();
        checkOutput("sim_avail", 32'(frames_avail), 1);
        checkOutput("sim_busy", 32'(busy), 0);
        replayFrame();

        sendRandom(3, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        idleCycle();
        idleCycle();
        checkOutput("mid_rd_word2", 32'(dataout), 32'(mData[1]));
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_data", 32'(dataout), 0);
        checkOutput("mid_rst_busy", 32'(busy), 0);
        checkOutput("mid_rst_flags", 32'({startoutput, stopoutput}), 0);
        checkOutput("mid_rst_avail", 32'(frames_avail), 0);
        #2 reset_n = 1'b1;
        mLen.delete();
        mData.delete();
        replayFrame();
        sendRandom(2, 1'b0, 0);
        replayFrame();

        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 9);
            if (op < 6) begin
                sendRandom($urandom_range(1, 12), $urandom_range(0, 3) == 0,
                           ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0);
            end else begin
                replayFrame();
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/pkt_frame_buf.md
PKT_FRAME_BUF -- requirements
Module: pkt_frame_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width (min 8).
REQ-002 SHALL have parameter DEPTH, default 64, buffer words (power of 2).
REQ-003 SHALL have parameter MAX_FRAMES, default 4, frames held simultaneously.
REQ-004 SHALL have port clock  input  1  single clock, all logic on posedge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  marks first payload word.
REQ-007 SHALL have port stop  input  1  marks last payload word.
REQ-008 SHALL have port datain  input  DATA_W  payload word; CRC byte in [7:0] on cycle after stop.
REQ-009 SHALL have port start_read  input  1  one-cycle request to replay oldest frame.
REQ-010 SHALL have port dataout  output  DATA_W  replayed word.
REQ-011 SHALL have port startoutput  output  1  marks first replayed word.
REQ-012 SHALL have port stopoutput  output  1  marks last replayed payload word.
REQ-013 SHALL have port frames_avail  output  $clog2(MAX_FRAMES+1)  committed unread frames.
REQ-014 SHALL have port busy  output  1  replay in progress.
REQ-015 SHALL have port crc_err  output  1  one-cycle pulse, frame rejected on CRC.
REQ-016 SHALL have port ovf  output  1  one-cycle pulse, frame dropped for space/table.

Function
REQ-017 Write FSM SHALL have states W_IDLE, W_DATA, W_CRC: start -> W_DATA (start&stop same cycle -> W_CRC, 1-word frame); stop -> W_CRC; CRC cycle -> W_IDLE.
REQ-018 Frame SHALL store payload words then the received CRC word; commit (length into frame table, frames_avail+1) at end of W_CRC cycle.
REQ-019 CRC SHALL be CRC-8, poly 0x07, init 0x00, over payload words' low 8 bits, MSB first.
REQ-020 start while in W_DATA SHALL abort current frame (write pointer rolled back) and begin a new frame; no pulse.
REQ-021 Frame exceeding free words, or starting with frame table full, SHALL be dropped: words ignored, pointer rolled back, ovf pulse on its CRC cycle.
REQ-022 start_read with frames_avail=0 or busy=1 SHALL be ignored.
REQ-023 Read FSM SHALL have states R_IDLE, R_DATA, R_CRC: start_read at cycle N -> first word with startoutput at N+1, one word per cycle, stopoutput with last payload word, stored CRC on dataout next cycle, then R_IDLE; frames_avail-1 at the R_CRC cycle.
REQ-024 busy SHALL be high from N+1 through the R_CRC cycle inclusive.
REQ-025 Simultaneous commit and replay-end SHALL leave frames_avail unchanged; frame committing in cycle N SHALL be readable from start_read in N+1.
REQ-026 Pointers SHALL wrap modulo DEPTH; free space = DEPTH minus words held by committed and in-progress-read frames.
REQ-027 dataout SHALL be 0 and startoutput/stopoutput 0 whenever busy=0.

Reset
REQ-028 reset_n low SHALL asynchronously clear pointers, frame table, FSMs to W_IDLE/R_IDLE, and drive dataout=0, startoutput=0, stopoutput=0, busy=0, frames_avail=0, crc_err=0, ovf=0.
REQ-029 Reset mid-frame or mid-replay SHALL discard all stored frames; first start after reset_n release begins a clean frame.

Configuration
REQ-030 With PKT_FRAME_BUF_CRC_CHECK_EN defined, received CRC SHALL be compared to computed CRC; mismatch discards frame and pulses crc_err.
REQ-031 Without PKT_FRAME_BUF_CRC_CHECK_EN, every non-dropped frame SHALL commit, crc_err tied 0, CRC logic absent; CRC cycle still consumed and stored.

Structure
REQ-032 Package pkt_frame_buf_pkg SHALL hold CRC8_POLY=8'h07, CRC8_INIT=8'h00, write/read state enums, crc8_next function.
REQ-033 Sub-module crc8_unit SHALL compute running CRC-8 (clear, enable, data, crc).

Verification
REQ-034 Frame 0x01,0x02 + CRC 0x1B, then start_read -> frames_avail 1->0, output 0x01(startoutput),0x02(stopoutput),0x1B.
REQ-035 Frame 0x01 + CRC 0x00 with CRC_CHECK_EN -> crc_err pulse, frames_avail stays 0; without macro -> frames_avail=1.
REQ-036 DEPTH=8, write 8-word payload frame -> ovf pulse, frames_avail 0; next 3-word frame commits normally.
REQ-037 MAX_FRAMES=4, commit 5 one-word frames -> 5th ovf, frames_avail=4; 4 replays in order, then start_read ignored.
REQ-038 reset_n low during replay word 2 -> all outputs 0 immediately, frames_avail=0, subsequent start_read ignored.
REQ-039 start_read in same cycle as a frame commit with frames_avail=0 -> ignored; start_read next cycle -> replay begins.
